// File: rtl/flopenr_pkg.sv
// -----------------------------------------------------------------------------
// flopenr_pkg
//   Shared constants and helpers for the basic storage/decode primitives
//   (flopenr, flopr, dec2).
//   Contents:
//     DEFAULT_WIDTH : default data width of the register primitives
//     onehot2()     : 2-bit binary to 4-bit one-hot decode
// -----------------------------------------------------------------------------
package flopenr_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Binary-to-one-hot for a 2-bit select. Every known input produces
    // exactly one set bit.
    function automatic logic [3:0] onehot2(input logic [1:0] a);
        onehot2 = 4'b0001 << a;
    endfunction

endpackage

// File: rtl/flopenr.sv
// -----------------------------------------------------------------------------
// Shared primitives: flopenr, flopr, dec2
//   Basic building blocks visible to every block of the codebase (cache,
//   write buffer, controllers).
//
// flopenr -- enabled register with synchronous active-high reset
//   ph1   in  1      clock; all state updates on its rising edge
//   ph2   in  1      complementary phase, present only for port compatibility
//   reset in  1      synchronous active-high reset (q -> 0), wins over en
//   en    in  1      load enable
//   d     in  WIDTH  next-state data
//   q     out WIDTH  registered state
//
// flopr -- register loading every edge, synchronous active-high reset
//   ph1, ph2, reset, d, q as for flopenr (no en)
//
// dec2 -- combinational 2-to-4 one-hot decoder
//   a     in  2      binary select
//   y     out 4      one-hot output
// -----------------------------------------------------------------------------

module flopenr
    import flopenr_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             ph1,
    input  logic             ph2,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // ph2 is carried for interface compatibility only; it drives nothing.
    logic unused_ph2;
    assign unused_ph2 = ph2;

    // Reset is tested first so it overrides en, including an unknown en.
    always_ff @(posedge ph1) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

module flopr
    import flopenr_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             ph1,
    input  logic             ph2,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // An always-enabled flopenr gives exactly the load-every-edge behaviour.
    flopenr #(.WIDTH(WIDTH)) u_reg (
        .ph1   (ph1),
        .ph2   (ph2),
        .reset (reset),
        .en    (1'b1),
        .d     (d),
        .q     (q)
    );

endmodule

module dec2
    import flopenr_pkg::*;
(
    input  logic [1:0] a,
    output logic [3:0] y
);

    assign y = onehot2(a);

endmodule

// File: tb/tb_flopenr.sv
// -----------------------------------------------------------------------------
// tb_flopenr
//   Bench for the shared primitives: flopenr (WIDTH 8 and 32), flopr (WIDTH 2)
//   and dec2. Inputs change on the ph1 falling edge; the driver pushes the
//   value each register should hold after the next rising edge into a queue,
//   and an independent monitor pops and compares shortly after that edge.
// -----------------------------------------------------------------------------
module tb_flopenr;

    // ---------------- clock / reset ----------------
    logic ph1 = 1'b0;
    logic ph2;
    always #5 ph1 = ~ph1;
    assign ph2 = ~ph1;

    // ---------------- DUT signals ----------------
    logic        rst8,  en8;
    logic [7:0]  d8,  q8;
    logic        rst32, en32;
    logic [31:0] d32, q32;
    logic        rstr;
    logic [1:0]  dr,  qr;
    logic [1:0]  dec_a;
    logic [3:0]  dec_y;

    flopenr #(.WIDTH(8)) dut8 (
        .ph1(ph1), .ph2(ph2), .reset(rst8), .en(en8), .d(d8), .q(q8)
    );
    flopenr #(.WIDTH(32)) dut32 (
        .ph1(ph1), .ph2(ph2), .reset(rst32), .en(en32), .d(d32), .q(q32)
    );
    flopr #(.WIDTH(2)) dutr (
        .ph1(ph1), .ph2(ph2), .reset(rstr), .d(dr), .q(qr)
    );
    dec2 dutd (
        .a(dec_a), .y(dec_y)
    );

    // ---------------- scoreboard ----------------
    logic [7:0]  exp8_q[$];
    logic [31:0] exp32_q[$];
    logic [1:0]  expr_q[$];

    // Reference state: what each register should contain.
    logic [7:0]  m8;
    logic [31:0] m32;
    logic [1:0]  mr;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge ph1) begin
        logic [7:0]  e8;
        logic [31:0] e32;
        logic [1:0]  er;
        #1;
        if (exp8_q.size() > 0) begin
            e8 = exp8_q.pop_front();
            chk("q8", {24'd0, q8}, {24'd0, e8});
        end
        if (exp32_q.size() > 0) begin
            e32 = exp32_q.pop_front();
            chk("q32", q32, e32);
        end
        if (expr_q.size() > 0) begin
            er = expr_q.pop_front();
            chk("flopr_q", {30'd0, qr}, {30'd0, er});
        end
    end

    // ---------------- driver ----------------
    // Called with inputs already set (at a falling edge): records what the
    // coming rising edge must produce, then waits for the next falling edge.
    task automatic cycle();
        if (rst8)       m8 = 8'h00;
        else if (en8)   m8 = d8;
        if (rst32)      m32 = 32'h0;
        else if (en32)  m32 = d32;
        mr = rstr ? 2'b00 : dr;
        exp8_q.push_back(m8);
        exp32_q.push_back(m32);
        expr_q.push_back(mr);
        @(negedge ph1);
    endtask

    // Toggle inputs between edges; q must not move.
    task automatic hold_between_edges();
        logic [7:0] sd;
        logic       se, sr;
        sd = d8; se = en8; sr = rst8;
        en8 = 1'b1;
        d8  = ~m8;
        #1 chk("no_comb_d", {24'd0, q8}, {24'd0, m8});
        d8  = m8 ^ 8'h55;
        rst8 = 1'b1;
        #1 chk("no_comb_reset", {24'd0, q8}, {24'd0, m8});
        d8 = sd; en8 = se; rst8 = sr;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        m8 = '0; m32 = '0; mr = '0;

        // Reset with en=1 and d=FF: reset wins.
        rst8 = 1'b1; en8 = 1'b1; d8 = 8'hFF;
        rst32 = 1'b1; en32 = 1'b1; d32 = 32'hFFFF_FFFF;
        rstr = 1'b1; dr = 2'b11;
        dec_a = 2'b00;
        cycle();

        // Load then hold.
        rst8 = 1'b0; rst32 = 1'b0; rstr = 1'b0;
        en8 = 1'b1; d8 = 8'hA5;
        en32 = 1'b0;
        dr = 2'b01;
        cycle();
        en8 = 1'b0; d8 = 8'h3C;
        dr = 2'b10;
        cycle();
        dr = 2'b11;
        cycle();
        cycle();
        hold_between_edges();

        // Reset together with en, mid-operation.
        rst8 = 1'b1; en8 = 1'b1; d8 = 8'h5A;
        rstr = 1'b1; dr = 2'b10;
        cycle();
        hold_between_edges();
        rst8 = 1'b0; en8 = 1'b0; rstr = 1'b0; dr = 2'b01;
        cycle();

        // Single-edge enable pulse on the 32-bit register, then hold.
        en32 = 1'b1; d32 = 32'hDEAD_BEEF;
        cycle();
        en32 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d32 = $urandom;
            cycle();
        end

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            rst8  = ($urandom_range(0, 15) == 0);
            rst32 = ($urandom_range(0, 15) == 0);
            rstr  = ($urandom_range(0, 15) == 0);
            en8   = $urandom_range(0, 1);
            en32  = ($urandom_range(0, 3) == 0);
            d8    = 8'($urandom);
            d32   = $urandom;
            dr    = 2'($urandom);
            cycle();
            if ($urandom_range(0, 19) == 0) hold_between_edges();
        end

        // dec2 exhaustive: one-hot at position a.
        for (int i = 0; i < 4; i++) begin
            dec_a = 2'(i);
            #1;
            chk("dec2_y", {28'd0, dec_y}, 32'd1 << i);
            chk("dec2_onehot", $countones(dec_y), 32'd1);
        end

        // Let the monitor drain; every expectation must have been consumed.
        @(posedge ph1);
        #3;
        chk("drain8",  exp8_q.size(),  0);
        chk("drain32", exp32_q.size(), 0);
        chk("drainr",  expr_q.size(),  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
